// File: rtl/memory_16kb_pkg.sv
// Shared sizing for the 16 KB byte memory: four 4 KB blocks selected by the
// top two address bits.
package memory_16kb_pkg;

  localparam int DATA_W     = 8;
  localparam int BLK_ADDR_W = 12;
  localparam int ADDR_W     = 14;
  localparam int NUM_BLKS   = 4;
  localparam int BLK_SEL_HI = 13;
  localparam int BLK_SEL_LO = 12;

  typedef logic [BLK_SEL_HI-BLK_SEL_LO:0] blk_sel_t;

  function automatic blk_sel_t blk_sel_of(input logic [ADDR_W-1:0] a);
    return a[BLK_SEL_HI:BLK_SEL_LO];
  endfunction

endpackage

// File: rtl/memory_4kb.sv
// One 4096 x 8 block: synchronous write, asynchronous read, no reset on the
// array so contents survive a top-level reset.
module memory_4kb
  import memory_16kb_pkg::*;
#(
  parameter int DW = memory_16kb_pkg::DATA_W,
  parameter int AW = memory_16kb_pkg::BLK_ADDR_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= data_in;
  end

  assign data_out = mem[addr];

endmodule

// File: rtl/memory_16kb.sv
// 16 KB byte memory built from four 4 KB blocks; addr[13:12] picks the block
// for both the write-enable decode and the read-data mux.
module memory_16kb
  import memory_16kb_pkg::*;
#(
  parameter int DATA_W     = memory_16kb_pkg::DATA_W,
  parameter int BLK_ADDR_W = memory_16kb_pkg::BLK_ADDR_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [memory_16kb_pkg::ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]                   data_in,
  input  logic                                we,
  output logic [DATA_W-1:0]                   data_out
);

  blk_sel_t                          sel;
  logic [NUM_BLKS-1:0]               blk_we;
  logic [NUM_BLKS-1:0][DATA_W-1:0]   blk_rd;

  assign sel = blk_sel_of(addr);

  // Reset suppresses writes here rather than in the blocks, leaving the array intact.
  always_comb begin
    blk_we = '0;
    if (we && !rst) blk_we[sel] = 1'b1;
  end

  for (genvar b = 0; b < NUM_BLKS; b++) begin : g_blk
    memory_4kb #(
      .DW (DATA_W),
      .AW (BLK_ADDR_W)
    ) u_blk (
      .clk      (clk),
      .we       (blk_we[b]),
      .addr     (addr[BLK_ADDR_W-1:0]),
      .data_in  (data_in),
      .data_out (blk_rd[b])
    );
  end

  always_comb begin
    data_out = blk_rd[sel];
    if (rst) data_out = '0;
  end

endmodule

// File: tb/tb_memory_16kb.sv
// Scoreboarded bench for memory_16kb: expected bytes come from a sparse model
// and are queued at drive time, then popped when data_out is sampled.
module tb_memory_16kb;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [13:0] addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;

  memory_16kb dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .we       (we),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_t;

  sb_t        sb_q[$];
  logic [7:0] model [int];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: data_out=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [7:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Sample 1ns after the drive point and retire the oldest expectation.
  task automatic sb_check();
    sb_t e;
    #1;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_empty: no expectation queued");
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, data_out, e.exp);
    end
  endtask

  task automatic wr(input logic [13:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; data_in = d; we = 1'b1;
    @(posedge clk);
    model[int'(a)] = d;
    #1 we = 1'b0;
  endtask

  task automatic rd(input logic [13:0] a, input string tag);
    @(negedge clk);
    addr = a; we = 1'b0;
    sb_push(tag, model[int'(a)]);
    sb_check();
  endtask

  initial begin
    logic [13:0] ra;
    logic [7:0]  rdat;
    rst = 1'b1; we = 1'b0; addr = 14'h0000; data_in = 8'h00;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    sb_push("reset_out", 8'h00);
    sb_check();
    addr = 14'h2abc;
    sb_push("reset_out2", 8'h00);
    sb_check();
    rst = 1'b0;

    // one word per block
    wr(14'h0000, 8'hA5); wr(14'h1000, 8'h5A); wr(14'h2000, 8'h3C); wr(14'h3000, 8'hC3);
    rd(14'h0000, "blk0"); rd(14'h1000, "blk1"); rd(14'h2000, "blk2"); rd(14'h3000, "blk3");

    // block boundaries
    wr(14'h0FFF, 8'h11); wr(14'h1000, 8'h22);
    wr(14'h1FFF, 8'h33); wr(14'h2000, 8'h44);
    wr(14'h2FFF, 8'h55); wr(14'h3000, 8'h66);
    rd(14'h0FFF, "bnd_0fff"); rd(14'h1000, "bnd_1000");
    rd(14'h1FFF, "bnd_1fff"); rd(14'h2000, "bnd_2000");
    rd(14'h2FFF, "bnd_2fff"); rd(14'h3000, "bnd_3000");

    // aliasing: same offset in the other blocks must keep their own values
    wr(14'h1123, 8'h01); wr(14'h2123, 8'h02); wr(14'h3123, 8'h03);
    wr(14'h0123, 8'h77);
    @(negedge clk);
    addr = 14'h0123; data_in = 8'h88; we = 1'b0;
    repeat (3) @(posedge clk);
    rd(14'h0123, "hold_0123");
    rd(14'h1123, "alias_1123"); rd(14'h2123, "alias_2123"); rd(14'h3123, "alias_3123");

    // reset blocks writes and forces zero output, array retained
    wr(14'h3FFF, 8'h5A);
    @(negedge clk);
    rst = 1'b1; we = 1'b1; data_in = 8'hFF; addr = 14'h3FFF;
    sb_push("rst_out_c0", 8'h00);
    sb_check();
    @(negedge clk);
    sb_push("rst_out_c1", 8'h00);
    sb_check();
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
    sb_push("post_rst_3fff", 8'h5A);
    sb_check();
    rd(14'h0000, "post_rst_0000");

    // write on the very first edge after reset release
    @(negedge clk);
    rst = 1'b1; we = 1'b0;
    @(negedge clk);
    rst = 1'b0; we = 1'b1; addr = 14'h3FFE; data_in = 8'h9D;
    @(posedge clk);
    model[int'(14'h3FFE)] = 8'h9D;
    #1 we = 1'b0;
    rd(14'h3FFE, "first_edge_wr");

    // read during write: old value before the edge, new after
    wr(14'h0040, 8'h10);
    @(negedge clk);
    addr = 14'h0040; data_in = 8'h20; we = 1'b1;
    sb_push("rdw_before", 8'h10);
    sb_check();
    @(posedge clk);
    model[int'(14'h0040)] = 8'h20;
    sb_push("rdw_after", 8'h20);
    sb_check();
    we = 1'b0;

    // random traffic on a few offsets in every block
    for (int i = 0; i < 300; i++) begin
      ra = {2'($urandom_range(0, 3)), 12'($urandom_range(0, 7) * 12'h1F1)};
      if ($urandom_range(0, 1) == 1 || !model.exists(int'(ra))) begin
        rdat = 8'($urandom_range(0, 255));
        wr(ra, rdat);
      end else begin
        rd(ra, "rand_rd");
      end
    end
    for (int i = 0; i < 32; i++) begin
      ra = {2'(i % 4), 12'((i / 4) * 12'h1F1)};
      if (model.exists(int'(ra))) rd(ra, "rand_sweep");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/memory_16kb.md
MEMORY_16KB -- requirements
Module: memory_16kb

Interface
REQ-001 Parameter DATA_W, default 8: data word width in bits; the design SHALL be verified only at this default.
REQ-002 Parameter BLK_ADDR_W, default 12: address width of one 4 KB block (4096 words).
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port addr, input, 14: byte address; addr[13:12] selects the block, addr[11:0] is the offset within the block.
REQ-006 Port data_in, input, 8: write data.
REQ-007 Port we, input, 1: write enable, active-high.
REQ-008 Port data_out, output, 8: read data.

Function
REQ-009 The memory SHALL hold 16384 words x 8 bits, organised as four 4096 x 8 blocks.
REQ-010 Block select SHALL be: addr[13:12]=00 -> block 0, 01 -> block 1, 10 -> block 2, 11 -> block 3.
REQ-011 On a rising clk edge with we=1 and rst=0, the write SHALL store data_in at offset addr[11:0] of the selected block only.
REQ-012 The other three blocks SHALL be unchanged by that write.
REQ-013 A write SHALL take effect at the edge where we is sampled high; there SHALL be no pipelining of address or data.
REQ-014 Reads SHALL be asynchronous: data_out = selected block[addr[11:0]] combinationally, independent of we.
REQ-015 Read latency SHALL be zero cycles: a new addr is reflected on data_out within the same cycle, before the next rising edge.
REQ-016 Read during write to the same address: before the edge, data_out SHALL show the old word; after the edge, it SHALL show the newly written word.
REQ-017 The address space SHALL be fully decoded, with no aliasing between blocks.
REQ-018 Addresses 0x0FFF->0x1000, 0x1FFF->0x2000 and 0x2FFF->0x3000 SHALL be treated as independent words in adjacent blocks.
REQ-019 Locations never written since power-up SHALL have undefined content; no initialisation is required.

Reset
REQ-020 While rst=1 at a rising edge, no write SHALL occur, regardless of we.
REQ-021 While rst=1, data_out SHALL be forced to 0x00.
REQ-022 Reset SHALL NOT clear the storage array; contents written before reset SHALL be readable after rst deasserts.
REQ-023 Deasserting rst SHALL allow a write on the very next rising edge.

Structure
REQ-024 A shared package SHALL hold: DATA_W=8, BLK_ADDR_W=12, ADDR_W=14, NUM_BLKS=4, and the block-index field position [13:12].
REQ-025 One sub-module, memory_4kb, SHALL be used.
REQ-026 memory_4kb ports SHALL be: clk, we, addr[11:0], data_in[7:0], data_out[7:0], with synchronous write and asynchronous read.
REQ-027 memory_16kb SHALL instantiate memory_4kb four times.
REQ-028 memory_16kb SHALL provide a 2-to-4 write-enable decoder driven by addr[13:12], we and !rst.
REQ-029 memory_16kb SHALL provide a 4-to-1 read-data multiplexer driven by addr[13:12], gated to 0x00 by rst.

Verification
REQ-030 Write 0xA5@0x0000, 0x5A@0x1000, 0x3C@0x2000 and 0xC3@0x3000, each for one cycle with we=1 -> reading the same addresses returns A5, 5A, 3C, C3.
REQ-031 Write 0x11@0x0FFF, then 0x22@0x1000 -> 0x0FFF reads 11 and 0x1000 reads 22; likewise across 0x1FFF/0x2000 and 0x2FFF/0x3000.
REQ-032 Write 0x77@0x0123, then hold we=0 and change data_in to 0x88 for 3 cycles -> 0x0123 still reads 77, and 0x1123, 0x2123, 0x3123 do not read 77.
REQ-033 Write 0x5A@0x3FFF, then assert rst with we=1, data_in=0xFF, addr=0x3FFF for 2 cycles -> data_out=00 during reset; after deassert, 0x3FFF reads 5A.
REQ-034 With addr=0x0040 holding 0x10, drive we=1 and data_in=0x20 -> data_out=10 before the edge and 20 after it.
